param_queue: RTL and testbench
==============================

PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter DATA_W, default 8: entry width in bits.
REQ-002 Parameter DEPTH, default 1024: entry count; SHALL be a power of two, >= 2.
REQ-003 Parameter AFULL_LVL, default DEPTH-4: occupancy at or above which afull_o asserts.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 flush_i  in  1  synchronous discard of all contents.
REQ-007 in_valid_i  in  1  producer offers in_data_i.
REQ-008 in_data_i  in  DATA_W  write data.
REQ-009 in_ready_o  out  1  queue can accept; equals !full.
REQ-010 out_valid_o  out  1  out_data_o holds the head entry; equals !empty.
REQ-011 out_data_o  out  DATA_W  head entry, first-word-fall-through.
REQ-012 out_ready_i  in  1  consumer takes head entry.
REQ-013 count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 full_o, empty_o, afull_o  out  1 each  status flags.

Function
REQ-015 Push SHALL occur on a cycle with in_valid_i && in_ready_o; pop on a cycle with out_valid_o && out_ready_i.
REQ-016 in_ready_o SHALL depend only on registered state; no combinational path from out_ready_i.
REQ-017 Pushed entry SHALL be visible on out_data_o with out_valid_o=1 the cycle after the push (1-cycle latency into an empty queue).
REQ-018 out_data_o SHALL update the cycle after a pop to the next entry; when empty its value is don't-care.
REQ-019 Simultaneous push and pop (queue neither empty nor full) SHALL leave count_o unchanged and advance both pointers.
REQ-020 When full, push SHALL be refused even if a pop occurs in the same cycle; pop still completes.
REQ-021 When empty, out_ready_i SHALL be ignored; no pointer change.
REQ-022 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gap.
REQ-023 count_o SHALL be tracked in a register, not derived from pointer difference; full_o = (count_o==DEPTH), empty_o = (count_o==0), afull_o = (count_o>=AFULL_LVL).
REQ-024 flush_i SHALL take priority over push and pop: next cycle count=0, pointers=0, any concurrent push discarded.
REQ-025 Entry order SHALL be strictly FIFO; no entry duplicated or lost except by flush or reset.

Reset
REQ-026 rst_n low SHALL immediately clear pointers and count: count_o=0, empty_o=1, full_o=0, afull_o=0, out_valid_o=0, in_ready_o=1.
REQ-027 Storage array SHALL NOT be reset; its contents are unobservable because empty_o=1.
REQ-028 Reset asserted mid-transfer SHALL abort it; the first push after deassertion lands at address 0.

Configuration
REQ-029 Macro PARAM_QUEUE_ERR_EN defined: adds outputs ovf_o, udf_o (1 bit each) and input err_clr_i; ovf_o sets sticky on in_valid_i && full_o, udf_o sets sticky on out_ready_i && empty_o; err_clr_i clears both next cycle (set wins when both coincide); both reset to 0.
REQ-030 Macro undefined: those ports and flops are absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold default DATA_W/DEPTH constants and the count-width function/constant used by both modules.
REQ-032 Storage SHALL be a sub-module param_queue_ram: DEPTH x DATA_W, one synchronous write port, one asynchronous read port, so a macro SRAM wrapper can replace it later.
REQ-033 Pointer/count/flag logic SHALL live in param_queue only.

Verification (DEPTH=8, AFULL_LVL=6, DATA_W=8)
REQ-034 Reset, push 0x11,0x22,0x33, then pop 3 -> out_data_o 0x11,0x22,0x33 in order; empty_o=1 and count_o=0 afterward.
REQ-035 Push 8 entries with out_ready_i=0 -> afull_o rises at count 6, full_o=1, in_ready_o=0 at count 8; 9th push refused, count stays 8.
REQ-036 Full queue, in_valid_i and out_ready_i both 1 one cycle -> one pop, no push, count_o=7; next cycle push accepted, count_o=8.
REQ-037 Stream 20 entries 0x00..0x13 with continuous push and pop at count 3 -> pointers wrap twice, output sequence exact, count_o constant at 3.
REQ-038 Count 5, flush_i=1 with concurrent push -> next cycle count_o=0, empty_o=1; rst_n pulsed low mid-stream -> flags at reset values asynchronously, before next clock edge.
REQ-039 With PARAM_QUEUE_ERR_EN: pop on empty -> udf_o=1 and held; push on full -> ovf_o=1; err_clr_i one cycle -> both 0.

Source files
------------

// File: rtl/param_queue_pkg.sv
// Shared constants and the count-width helper for the param_queue slice.
package param_queue_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 1024;

    // The occupancy counter needs one extra bit so that it can hold DEPTH itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/param_queue_ram.sv
// Storage for param_queue: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port. It has no reset, so a macro SRAM wrapper can replace it.
module param_queue_ram
    import param_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read gives first-word-fall-through at the queue head.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/param_queue.sv
// Parameterised FWFT queue with a valid/ready interface, a registered occupancy
// count and status flags. Define PARAM_QUEUE_ERR_EN to add the sticky overflow
// and underflow flags (ovf_o, udf_o) and their clear input (err_clr_i).
module param_queue
    import param_queue_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AFULL_LVL = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       out_ready_i,
    output logic [cnt_w(DEPTH)-1:0]    count_o,
`ifdef PARAM_QUEUE_ERR_EN
    input  logic                       err_clr_i,
    output logic                       ovf_o,
    output logic                       udf_o,
`endif
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       afull_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = cnt_w(DEPTH);

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;

    // Flags come straight from the count register, so in_ready_o never sees out_ready_i.
    always_comb begin
        full        = (count_q == CntW'(DEPTH));
        empty       = (count_q == '0);
        push        = in_valid_i && !full;
        pop         = out_ready_i && !empty;
        in_ready_o  = !full;
        out_valid_o = !empty;
        full_o      = full;
        empty_o     = empty;
        afull_o     = (count_q >= CntW'(AFULL_LVL));
        count_o     = count_q;
    end

    // Pointer and count update; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

`ifdef PARAM_QUEUE_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (in_valid_i && full) begin
                ovf_q <= 1'b1;
            end else if (err_clr_i) begin
                ovf_q <= 1'b0;
            end
            if (out_ready_i && empty) begin
                udf_q <= 1'b1;
            end else if (err_clr_i) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Expose the sticky flags.
    always_comb begin
        ovf_o = ovf_q;
        udf_o = udf_q;
    end
`endif

    param_queue_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (push && !flush_i),
        .waddr  (wr_ptr_q),
        .wdata  (in_data_i),
        .raddr  (rd_ptr_q),
        .rdata  (out_data_o)
    );

endmodule

// File: tb/tb_param_queue.sv
// Self-checking bench for param_queue (DEPTH=8, AFULL_LVL=6, DATA_W=8).
// A scoreboard queue holds the expected contents; heads are compared on pops.
module tb_param_queue;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AFULL_LVL = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i = 1'b0;
    logic [3:0]        count_o;
    logic              full_o;
    logic              empty_o;
    logic              afull_o;
`ifdef PARAM_QUEUE_ERR_EN
    logic              err_clr_i = 1'b0;
    logic              ovf_o;
    logic              udf_o;
`endif

    logic [DATA_W-1:0] sb [$];
    int                exp_cnt = 0;
    int                checks  = 0;
    int                passes  = 0;

    param_queue #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
`ifdef PARAM_QUEUE_ERR_EN
        .err_clr_i   (err_clr_i),
        .ovf_o       (ovf_o),
        .udf_o       (udf_o),
`endif
        .full_o      (full_o),
        .empty_o     (empty_o),
        .afull_o     (afull_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock, update the reference model, then idle the inputs.
    task automatic tick();
        logic              push_ok;
        logic              pop_ok;
        logic              fl;
        logic [DATA_W-1:0] d;
        fl      = flush_i;
        d       = in_data_i;
        push_ok = in_valid_i && (exp_cnt < DEPTH) && !fl;
        pop_ok  = out_ready_i && (exp_cnt > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            if (pop_ok) begin
                void'(sb.pop_front());
                exp_cnt--;
            end
            if (push_ok) begin
                sb.push_back(d);
                exp_cnt++;
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({count_o, empty_o, full_o, afull_o, out_valid_o, in_ready_o} !== {4'd0, 5'b10001}) begin
            $display("FAIL reset_flags: cnt=%0d e=%b f=%b af=%b ov=%b ir=%b want 0 1 0 0 0 1",
                     count_o, empty_o, full_o, afull_o, out_valid_o, in_ready_o);
        end else passes++;
`ifdef PARAM_QUEUE_ERR_EN
        checks++;
        if ({ovf_o, udf_o} !== 2'b00) begin
            $display("FAIL reset_err: ovf=%b udf=%b want 0 0", ovf_o, udf_o);
        end else passes++;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = vals[i];
            tick();
            if (i == 0) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== 8'h11) begin
                    $display("FAIL basic_latency: valid=%b data=%h want 1 11", out_valid_o, out_data_o);
                end else passes++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            out_ready_i = 1'b1;
            checks++;
            if (out_data_o !== vals[i] || sb[0] !== vals[i]) begin
                $display("FAIL basic_pop%0d: data=%h want %h", i, out_data_o, vals[i]);
            end else passes++;
            tick();
        end
        checks++;
        if (empty_o !== 1'b1 || count_o !== 4'd0) begin
            $display("FAIL basic_empty: empty=%b cnt=%0d want 1 0", empty_o, count_o);
        end else passes++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'hA0 + 8'(i);
            tick();
            checks++;
            if (count_o !== 4'(exp_cnt) || afull_o !== (exp_cnt >= AFULL_LVL) ||
                full_o !== (exp_cnt == DEPTH) || in_ready_o !== (exp_cnt != DEPTH)) begin
                $display("FAIL fill_%0d: cnt=%0d af=%b f=%b ir=%b want cnt=%0d",
                         i, count_o, afull_o, full_o, in_ready_o, exp_cnt);
            end else passes++;
        end
        checks++;
        if (count_o !== 4'd8) begin
            $display("FAIL fill_refused: cnt=%0d want 8", count_o);
        end else passes++;
    endtask

    task automatic test_full_pop_push();
        in_valid_i  = 1'b1;
        in_data_i   = 8'hEE;
        out_ready_i = 1'b1;
        checks++;
        if (out_data_o !== sb[0]) begin
            $display("FAIL fullpp_head: data=%h want %h", out_data_o, sb[0]);
        end else passes++;
        tick();
        checks++;
        if (count_o !== 4'd7 || in_ready_o !== 1'b1) begin
            $display("FAIL fullpp_pop: cnt=%0d ir=%b want 7 1", count_o, in_ready_o);
        end else passes++;
        in_valid_i = 1'b1;
        in_data_i  = 8'hB8;
        tick();
        checks++;
        if (count_o !== 4'd8 || full_o !== 1'b1) begin
            $display("FAIL fullpp_push: cnt=%0d full=%b want 8 1", count_o, full_o);
        end else passes++;
        for (int i = 0; i < 8; i++) begin
            out_ready_i = 1'b1;
            checks++;
            if (out_data_o !== sb[0]) begin
                $display("FAIL fullpp_drain%0d: data=%h want %h", i, out_data_o, sb[0]);
            end else passes++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i);
            if (i >= 3) begin
                out_ready_i = 1'b1;
                checks++;
                if (out_data_o !== 8'(i - 3) || sb[0] !== 8'(i - 3)) begin
                    $display("FAIL stream_data%0d: data=%h want %h", i, out_data_o, 8'(i - 3));
                end else passes++;
            end
            tick();
            if (i >= 2) begin
                checks++;
                if (count_o !== 4'd3) begin
                    $display("FAIL stream_cnt%0d: cnt=%0d want 3", i, count_o);
                end else passes++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            out_ready_i = 1'b1;
            checks++;
            if (out_data_o !== 8'(17 + i)) begin
                $display("FAIL stream_tail%0d: data=%h want %h", i, out_data_o, 8'(17 + i));
            end else passes++;
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'h40 + 8'(i);
            tick();
        end
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h55;
        tick();
        checks++;
        if (count_o !== 4'd0 || empty_o !== 1'b1 || out_valid_o !== 1'b0) begin
            $display("FAIL flush: cnt=%0d empty=%b ov=%b want 0 1 0", count_o, empty_o, out_valid_o);
        end else passes++;
        in_valid_i = 1'b1;
        in_data_i  = 8'h66;
        tick();
        checks++;
        if (count_o !== 4'd1 || out_data_o !== 8'h66) begin
            $display("FAIL flush_after: cnt=%0d data=%h want 1 66", count_o, out_data_o);
        end else passes++;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'h70 + 8'(i);
            tick();
        end
        // Reset lands mid-cycle with a transfer in flight.
        in_valid_i  = 1'b1;
        in_data_i   = 8'h99;
        out_ready_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count_o, empty_o, full_o, afull_o, out_valid_o, in_ready_o} !== {4'd0, 5'b10001}) begin
            $display("FAIL async_reset: cnt=%0d e=%b f=%b af=%b ov=%b ir=%b want 0 1 0 0 0 1",
                     count_o, empty_o, full_o, afull_o, out_valid_o, in_ready_o);
        end else passes++;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        tick();
        checks++;
        if (count_o !== 4'd1 || out_data_o !== 8'h77) begin
            $display("FAIL reset_after: cnt=%0d data=%h want 1 77", count_o, out_data_o);
        end else passes++;
        out_ready_i = 1'b1;
        tick();
    endtask

`ifdef PARAM_QUEUE_ERR_EN
    task automatic test_err();
        out_ready_i = 1'b1;
        tick();
        tick();
        checks++;
        if (udf_o !== 1'b1 || ovf_o !== 1'b0) begin
            $display("FAIL err_udf: udf=%b ovf=%b want 1 0", udf_o, ovf_o);
        end else passes++;
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i);
            tick();
        end
        checks++;
        if (ovf_o !== 1'b1 || udf_o !== 1'b1) begin
            $display("FAIL err_ovf: ovf=%b udf=%b want 1 1", ovf_o, udf_o);
        end else passes++;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checks++;
        if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin
            $display("FAIL err_clr: ovf=%b udf=%b want 0 0", ovf_o, udf_o);
        end else passes++;
        flush_i = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_pop_push();
        test_back_to_back();
        test_flush();
`ifdef PARAM_QUEUE_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
